// File: rtl/input_conditioner_if.sv
// Pin-side and SoC-side signals of the input conditioner.
// master = board/SoC side driving pins and clears; slave = the conditioner.
interface input_conditioner_if #(
    parameter int N_SW  = 24,
    parameter int N_BTN = 5
);
    logic [N_SW-1:0]  sw_pin_i;
    logic [N_BTN-1:0] btn_pin_i;
    logic [N_BTN-1:0] evt_clr_i;
    logic [N_SW-1:0]  sw_o;
    logic [N_BTN-1:0] btn_o;
    logic [N_BTN-1:0] btn_press_o;
    logic [N_BTN-1:0] btn_release_o;
    logic [N_BTN-1:0] btn_evt_o;

    modport master (
        output sw_pin_i, btn_pin_i, evt_clr_i,
        input  sw_o, btn_o, btn_press_o, btn_release_o, btn_evt_o
    );

    modport slave (
        input  sw_pin_i, btn_pin_i, evt_clr_i,
        output sw_o, btn_o, btn_press_o, btn_release_o, btn_evt_o
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronizes and debounces switch/button pins; produces press/release
// pulses and sticky, software-clearable press flags for the buttons.
module input_conditioner #(
    parameter int N_SW         = 24,
    parameter int N_BTN        = 5,
    parameter int TICK_DIV     = 20000,
    parameter int STABLE_TICKS = 10
) (
    input logic                clk_i,
    input logic                rst_i,
    input_conditioner_if.slave bus
);
    localparam int N  = N_SW + N_BTN;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS) + 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_TICKS - 1);

    // Switches occupy the low bits, buttons the top N_BTN bits.
    logic [N-1:0]     pins;
    logic [N-1:0]     s1;
    logic [N-1:0]     s2;
    logic [N-1:0]     deb;
    logic [N-1:0]     flip;
    logic [CW-1:0]    cnt [N];
    logic [TW-1:0]    tick_cnt;
    logic             tick;
    logic [N_BTN-1:0] btn_flip;
    logic [N_BTN-1:0] btn_s2;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] rel_q;
    logic [N_BTN-1:0] evt_q;

    assign pins     = {bus.btn_pin_i, bus.sw_pin_i};
    assign tick     = (tick_cnt == TICK_MAX);
    assign btn_flip = flip[N-1:N_SW];
    assign btn_s2   = s2[N-1:N_SW];

    // A bit flips on the tick that completes its run of mismatching ticks.
    always_comb begin
        flip = '0;
        for (int i = 0; i < N; i++) begin
            flip[i] = (s2[i] != deb[i]) && tick && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            s1       <= '0;
            s2       <= '0;
            deb      <= '0;
            tick_cnt <= '0;
            press_q  <= '0;
            rel_q    <= '0;
            evt_q    <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1       <= pins;
            s2       <= s1;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            for (int i = 0; i < N; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (flip[i]) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else if (tick) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            press_q <= btn_flip & btn_s2;
            rel_q   <= btn_flip & ~btn_s2;
            // Set comes from the registered press pulse and beats a same-cycle clear.
            evt_q   <= press_q | (evt_q & ~bus.evt_clr_i);
        end
    end

    assign bus.sw_o          = deb[N_SW-1:0];
    assign bus.btn_o         = deb[N-1:N_SW];
    assign bus.btn_press_o   = press_q;
    assign bus.btn_release_o = rel_q;
    assign bus.btn_evt_o     = evt_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with TICK_DIV=4, STABLE_TICKS=3.
module tb_input_conditioner;
    localparam int N_SW         = 24;
    localparam int N_BTN        = 5;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    input_conditioner_if #(.N_SW(N_SW), .N_BTN(N_BTN)) bus ();

    input_conditioner #(
        .N_SW(N_SW), .N_BTN(N_BTN), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    // scoreboard
    int n_cmp = 0;
    int n_err = 0;
    logic [N_BTN-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(negedge clk);
    endtask

    int k;
    int rel_cnt;
    logic [N_BTN-1:0] rel_acc;
    logic [2:0] acc3;
    logic acc1;
    logic both;
    logic b;

    initial begin
        bus.sw_pin_i  = '1;
        bus.btn_pin_i = '1;
        bus.evt_clr_i = '0;
        rst = 1'b0;

        // Reset with all pins high
        repeat (3) begin
            step();
            check_eq("rst_btn_outs", {bus.btn_o, bus.btn_press_o, bus.btn_release_o, bus.btn_evt_o}, 0);
            check_eq("rst_sw_o", bus.sw_o, 0);
        end
        rst = 1'b1;
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bus.btn_o == 5'h1F) begin k = c; break; end
        end
        check_eq("rst_rel_lat_ok", (k >= 1 && k <= 14), 1);
        check_eq("rst_rel_sw", bus.sw_o, 24'hFFFFFF);
        exp_q = '{5'h1F, 5'h00, 5'h00};
        while (exp_q.size() > 0) begin
            check_eq("rst_rel_press", bus.btn_press_o, exp_q.pop_front());
            step();
        end
        check_eq("rst_rel_evt", bus.btn_evt_o, 5'h1F);

        // Release everything, switches to a pattern
        bus.btn_pin_i = '0;
        bus.sw_pin_i  = 24'h5A5A5A;
        rel_acc = '0;
        repeat (16) begin
            step();
            rel_acc |= bus.btn_release_o;
        end
        check_eq("all_rel_btn", bus.btn_o, 0);
        check_eq("all_rel_pulses", rel_acc, 5'h1F);
        check_eq("pattern_sw", bus.sw_o, 24'h5A5A5A);
        check_eq("evt_sticky", bus.btn_evt_o, 5'h1F);
        bus.evt_clr_i = '1;
        step();
        bus.evt_clr_i = '0;
        check_eq("evt_clear_all", bus.btn_evt_o, 0);

        // Clean press on button 0
        bus.btn_pin_i[0] = 1'b1;
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bus.btn_o[0]) begin k = c; break; end
        end
        check_eq("press0_lat_ok", (k >= 11 && k <= 14), 1);
        check_eq("press0_pulse", bus.btn_press_o, 5'h01);
        step();
        check_eq("press0_pulse_end", bus.btn_press_o, 0);
        check_eq("press0_level", bus.btn_o, 5'h01);
        check_eq("press0_evt", bus.btn_evt_o, 5'h01);
        repeat (5) step();
        check_eq("press0_evt_hold", bus.btn_evt_o, 5'h01);

        // Glitch on button 2
        bus.btn_pin_i[2] = 1'b1;
        repeat (5) step();
        bus.btn_pin_i[2] = 1'b0;
        acc3 = '0;
        repeat (20) begin
            step();
            acc3 |= {bus.btn_o[2], bus.btn_press_o[2], bus.btn_evt_o[2]};
        end
        check_eq("glitch_rejected", acc3, 0);

        // Bounce on switch 7
        b = 1'b0;
        acc1 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 0) b = ~b;
            bus.sw_pin_i[7] = b;
            step();
            acc1 |= bus.sw_o[7];
        end
        check_eq("bounce_quiet", acc1, 0);
        bus.sw_pin_i[7] = 1'b1;
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bus.sw_o[7]) begin k = c; break; end
        end
        check_eq("bounce_settle_ok", (k >= 1 && k <= 14), 1);
        check_eq("bounce_sw", bus.sw_o, 24'h5A5ADA);

        // Event clear race on button 1
        bus.btn_pin_i[1] = 1'b1;
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bus.btn_press_o[1]) begin k = c; break; end
        end
        check_eq("race_press_seen", (k >= 11 && k <= 14), 1);
        bus.evt_clr_i = 5'h02;
        step();
        check_eq("race_set_wins", bus.btn_evt_o[1], 1);
        step();
        check_eq("race_clr_next", bus.btn_evt_o[1], 0);
        step();
        check_eq("clr_zero_noeffect", bus.btn_evt_o[1], 0);
        bus.evt_clr_i = '0;
        check_eq("race_other_evt", bus.btn_evt_o[0], 1);

        // Release on button 3
        bus.btn_pin_i[3] = 1'b1;
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bus.btn_o[3]) begin k = c; break; end
        end
        check_eq("btn3_up_ok", (k >= 11 && k <= 14), 1);
        bus.btn_pin_i[3] = 1'b0;
        rel_cnt = 0;
        acc1 = 1'b0;
        both = 1'b0;
        repeat (20) begin
            step();
            rel_cnt += int'(bus.btn_release_o[3]);
            acc1 |= bus.btn_press_o[3];
            both |= |(bus.btn_press_o & bus.btn_release_o);
        end
        check_eq("rel3_level", bus.btn_o[3], 0);
        check_eq("rel3_pulses", rel_cnt, 1);
        check_eq("rel3_no_press", acc1, 0);
        check_eq("press_rel_exclusive", both, 0);

        // Press again, reset mid-count
        bus.btn_pin_i[3] = 1'b1;
        repeat (6) step();
        rst = 1'b0;
        step();
        check_eq("midrst_clear", {bus.btn_o, bus.btn_press_o, bus.btn_evt_o}, 0);
        rst = 1'b1;
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bus.btn_press_o[3]) begin k = c; break; end
        end
        check_eq("midrst_full_latency", (k >= 11 && k <= 14), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
